rk_sector_dma: RTL

//  Parametrised sector DMA sequencer between the SD sector stream and PDP-8 memory for RK8E emulation.

---
 rtl/rk_sector_dma.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rk_sector_dma.sv
// Sector DMA sequencer between the SD word streams and the PDP-8 DMA port (RK8E emulation).
// Optional RK_FIELD_WRAP_EN: address increment stays within the current 4K field.
module rk_sector_dma #(
  parameter int unsigned WORD_W     = 12,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned SECT_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic              op,
  input  logic              len,
  input  logic [ADDR_W-1:0] memADDR,
  input  logic              rdVALID,
  input  logic [WORD_W-1:0] rdDATA,
  output logic              rdREADY,
  output logic              wrVALID,
  output logic [WORD_W-1:0] wrDATA,
  input  logic              wrREADY,
  output logic              dmaREQ,
  input  logic              dmaGNT,
  output logic [ADDR_W-1:0] dmaADDR,
  output logic              dmaRD,
  output logic              dmaWR,
  output logic [WORD_W-1:0] dmaDOUT,
  input  logic [WORD_W-1:0] dmaDIN,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] curADDR
);

  localparam int unsigned CNT_W = $clog2(SECT_WORDS) + 1;
  localparam int unsigned HALF  = SECT_WORDS / 2;

  typedef enum logic [2:0] {IDLE, XFER, DISCARD, PAD, DRAIN, DONE} state_t;

  state_t             state, stateNext;
  logic               opWrite, lenHalf, full;
  logic [WORD_W-1:0]  hold;
  logic [ADDR_W-1:0]  addr, addrInc;
  logic [CNT_W-1:0]   cnt, target;
  logic               capture, grant, emit, step;

  assign target  = lenHalf ? CNT_W'(HALF) : CNT_W'(SECT_WORDS);
  assign dmaADDR = addr;
  assign curADDR = addr;

  // Next memory address; the wrap variant keeps the field bits fixed
  always_comb begin
`ifdef RK_FIELD_WRAP_EN
    addrInc = {addr[ADDR_W-1:12], addr[11:0] + 12'(1)};
`else
    addrInc = addr + ADDR_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= stateNext;
  end

  // Next state, handshake outputs and datapath strobes, all decoded from registered state
  always_comb begin
    stateNext = state;
    rdREADY   = 1'b0;
    wrVALID   = 1'b0;
    wrDATA    = '0;
    dmaREQ    = 1'b0;
    dmaRD     = 1'b0;
    dmaWR     = 1'b0;
    dmaDOUT   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    grant     = 1'b0;
    emit      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = XFER;
      XFER: begin
        busy = 1'b1;
        if (!opWrite) begin
          rdREADY = !full && (cnt != target);
          dmaREQ  = full;
          dmaWR   = full;
          dmaDOUT = hold;
          capture = rdREADY && rdVALID;
          grant   = full && dmaGNT;
          if (cnt == target) stateNext = lenHalf ? DISCARD : DONE;
        end else begin
          dmaREQ  = !full && (cnt != target);
          dmaRD   = dmaREQ;
          grant   = dmaREQ && dmaGNT;
          wrVALID = full;
          wrDATA  = hold;
          emit    = full && wrREADY;
          if (cnt == target) stateNext = lenHalf ? PAD : DRAIN;
        end
      end
      DISCARD: begin
        busy    = 1'b1;
        rdREADY = 1'b1;
        step    = rdVALID;
        if (rdVALID && cnt == CNT_W'(SECT_WORDS - 1)) stateNext = DONE;
      end
      PAD: begin
        // Last data word still held goes out first, then the zero fill
        busy    = 1'b1;
        wrVALID = 1'b1;
        if (full) begin
          wrDATA = hold;
          emit   = wrREADY;
        end else begin
          step = wrREADY;
          if (wrREADY && cnt == CNT_W'(SECT_WORDS - 1)) stateNext = DONE;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        wrVALID = full;
        wrDATA  = hold;
        emit    = full && wrREADY;
        if (!full || wrREADY) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operation registers, holding register, address and word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opWrite <= 1'b0;
      lenHalf <= 1'b0;
      full    <= 1'b0;
      hold    <= '0;
      addr    <= '0;
      cnt     <= '0;
    end else if (clear) begin
      opWrite <= 1'b0;
      lenHalf <= 1'b0;
      full    <= 1'b0;
      hold    <= '0;
      addr    <= '0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      opWrite <= op;
      lenHalf <= len;
      full    <= 1'b0;
      hold    <= '0;
      addr    <= memADDR;
      cnt     <= '0;
    end else begin
      if (capture) begin
        hold <= rdDATA;
        full <= 1'b1;
      end
      if (grant) begin
        addr <= addrInc;
        cnt  <= cnt + CNT_W'(1);
        if (opWrite) begin
          hold <= dmaDIN;
          full <= 1'b1;
        end else begin
          full <= 1'b0;
        end
      end
      if (emit) full <= 1'b0;
      if (step) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
